// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment display blocks:
// scan state encoding, blank pattern and hex-to-segment table.
package seg_pkg;

    typedef enum logic {
        DRIVE = 1'b0,
        GAP   = 1'b1
    } scan_state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low {dp,g,f,e,d,c,b,a}; entry 0 is the rightmost element
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6,
        8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99,
        8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble plus decimal point to active-low segment pattern.
// Shared by every display block that drives the segment bus.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] catode
);

    logic [7:0] seg;

    assign seg    = SEG_TABLE[nibble];
    assign catode = {seg[7] & ~dp, seg[6:0]};

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode scan controller with a blanking gap between digits
// and a one-deep pending slot that is committed only at frame boundaries.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter bit LZ_BLANK    = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    input  logic [3:0]  load_dp,
    output logic        load_ready,
    output logic [3:0]  anode,
    output logic [7:0]  catode,
    output logic [1:0]  digit_idx,
    output logic        frame_done
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    scan_state_t   state;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   shown_data;
    logic [3:0]    shown_dp;
    logic [15:0]   pend_data;
    logic [3:0]    pend_dp;
    logic          pend_full;

    logic       boundary;
    logic       take;
    logic [3:0] nibble;
    logic       dp_bit;
    logic [7:0] seg_raw;
    logic       lz_zero;
    logic       blank;

    assign boundary   = (state == GAP) && (idx == 2'd3);
    assign load_ready = ~pend_full & ~reset;
    assign take       = load_valid & load_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= DRIVE;
            cnt        <= '0;
            idx        <= 2'd0;
            shown_data <= '0;
            shown_dp   <= '0;
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_full  <= 1'b0;
        end else begin
            unique case (state)
                DRIVE: begin
                    if (cnt == CNT_LAST) begin
                        state <= GAP;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    state <= DRIVE;
                    idx   <= idx + 2'd1;
                end
            endcase
            // A word taken on the boundary edge waits a full frame (no bypass)
            if (take) begin
                pend_data <= load_data;
                pend_dp   <= load_dp;
                pend_full <= 1'b1;
            end else if (boundary && pend_full) begin
                shown_data <= pend_data;
                shown_dp   <= pend_dp;
                pend_full  <= 1'b0;
            end
        end
    end

    assign nibble    = shown_data[idx*4 +: 4];
    assign dp_bit    = shown_dp[idx];
    assign digit_idx = idx;

    seg_hex_decode u_dec (
        .nibble (nibble),
        .dp     (dp_bit),
        .catode (seg_raw)
    );

    always_comb begin
        lz_zero = 1'b0;
        unique case (idx)
            2'd0: lz_zero = 1'b0;
            2'd1: lz_zero = (shown_data[15:4] == 12'd0);
            2'd2: lz_zero = (shown_data[15:8] == 8'd0);
            2'd3: lz_zero = (shown_data[15:12] == 4'd0);
        endcase
    end

    assign blank = LZ_BLANK && lz_zero;

    always_comb begin
        anode      = 4'b1111;
        catode     = SEG_BLANK;
        frame_done = 1'b0;
        if (state == DRIVE) begin
            anode  = ~(4'b0001 << idx);
            catode = blank ? {~dp_bit, SEG_BLANK[6:0]} : seg_raw;
        end else begin
            frame_done = (idx == 2'd3);
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (REFRESH_DIV=4): expected samples are
// queued per cycle; a negedge monitor pops and compares them.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid;
    logic [15:0] load_data;
    logic [3:0]  load_dp;

    logic       rdy0, rdy1, fd0, fd1;
    logic [3:0] an0, an1;
    logic [7:0] ca0, ca1;
    logic [1:0] di0, di1;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.REFRESH_DIV(4), .LZ_BLANK(1'b0)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_dp    (load_dp),
        .load_ready (rdy0),
        .anode      (an0),
        .catode     (ca0),
        .digit_idx  (di0),
        .frame_done (fd0)
    );

    seg_scan_ctrl #(.REFRESH_DIV(4), .LZ_BLANK(1'b1)) u_lz (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_dp    (load_dp),
        .load_ready (rdy1),
        .anode      (an1),
        .catode     (ca1),
        .digit_idx  (di1),
        .frame_done (fd1)
    );

    typedef struct {
        int         cyc;
        bit         lz;
        bit         disp;
        bit         rdy_chk;
        logic [3:0] an;
        logic [7:0] ca;
        logic [1:0] di;
        logic       fd;
        logic       rdy;
        string      name;
    } exp_t;

    exp_t q[$];
    int   tick = 0;
    int   base = 0;
    int   ncmp = 0;
    int   nerr = 0;

    always @(posedge clk) tick <= tick + 1;

    task automatic check(input exp_t e);
        logic [3:0] an;
        logic [7:0] ca;
        logic [1:0] di;
        logic       fd;
        logic       rdy;
        bit         bad;
        an  = e.lz ? an1 : an0;
        ca  = e.lz ? ca1 : ca0;
        di  = e.lz ? di1 : di0;
        fd  = e.lz ? fd1 : fd0;
        rdy = e.lz ? rdy1 : rdy0;
        bad = 1'b0;
        ncmp++;
        if (e.cyc < tick) begin
            $display("FAIL %s: sample for tick %0d missed (now %0d)",
                     e.name, e.cyc, tick);
            bad = 1'b1;
        end else begin
            if (e.disp && ({an, ca, di, fd} !== {e.an, e.ca, e.di, e.fd})) begin
                $display("FAIL %s: got an=%b ca=%h idx=%0d fd=%b, want an=%b ca=%h idx=%0d fd=%b",
                         e.name, an, ca, di, fd, e.an, e.ca, e.di, e.fd);
                bad = 1'b1;
            end
            if (e.rdy_chk && (rdy !== e.rdy)) begin
                $display("FAIL %s: got load_ready=%b, want %b", e.name, rdy, e.rdy);
                bad = 1'b1;
            end
        end
        if (bad) nerr++;
    endtask

    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc <= tick) begin
                check(q[i]);
                q.delete(i);
            end
        end
    end

    task automatic push_rdy(input int rel, input logic r, input string tag);
        exp_t e;
        e = '{cyc: base + rel, lz: 1'b0, disp: 1'b0, rdy_chk: 1'b1,
              an: 4'h0, ca: 8'h00, di: 2'd0, fd: 1'b0, rdy: r,
              name: $sformatf("%s_rdy_c%0d", tag, rel)};
        q.push_back(e);
    endtask

    task automatic push_disp(input int rel, input bit lz, input logic [3:0] an,
                             input logic [7:0] ca, input logic [1:0] di,
                             input logic fd, input string tag);
        exp_t e;
        e = '{cyc: base + rel, lz: lz, disp: 1'b1, rdy_chk: 1'b0,
              an: an, ca: ca, di: di, fd: fd, rdy: 1'b0,
              name: $sformatf("%s_c%0d", tag, rel)};
        q.push_back(e);
    endtask

    // Frame n (1-based) spans cycles 20*(n-1) .. 20*n-1
    task automatic push_frame(input bit lz, input int fnum,
                              input logic [7:0] c0, input logic [7:0] c1,
                              input logic [7:0] c2, input logic [7:0] c3,
                              input string tag);
        logic [7:0] cs [4];
        logic [3:0] an;
        int         st;
        cs[0] = c0; cs[1] = c1; cs[2] = c2; cs[3] = c3;
        st = (fnum - 1) * 20;
        for (int d = 0; d < 4; d++) begin
            an = ~(4'b0001 << d);
            for (int k = 0; k < 4; k++)
                push_disp(st + 5*d + k, lz, an, cs[d], 2'(d), 1'b0, tag);
            push_disp(st + 5*d + 4, lz, 4'b1111, 8'hFF, 2'(d), (d == 3), tag);
        end
    endtask

    task automatic goto(input int rel);
        while (tick < base + rel) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input int rel, input logic [15:0] d, input logic [3:0] p);
        goto(rel);
        load_valid = 1'b1;
        load_data  = d;
        load_dp    = p;
        goto(rel + 1);
        load_valid = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        exp_t e;
        reset      = 1'b1;
        load_valid = 1'b0;
        e = '{cyc: tick, lz: 1'b0, disp: 1'b0, rdy_chk: 1'b1,
              an: 4'h0, ca: 8'h00, di: 2'd0, fd: 1'b0, rdy: 1'b0,
              name: {tag, "_rdy_in_reset"}};
        q.push_back(e);
        @(posedge clk);
        #1;
        reset = 1'b0;
        base  = tick;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (q.size() > 0) begin
            foreach (q[i]) begin
                ncmp++;
                nerr++;
                $display("FAIL %s: never sampled (tick %0d)", q[i].name, q[i].cyc);
            end
            q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, %0d compared", ncmp);
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = 16'h0;
        load_dp    = 4'h0;
        @(posedge clk);
        #1;

        // 1: idle sweep after reset
        do_reset("t1");
        push_rdy(0, 1'b1, "t1");
        push_frame(1'b0, 1, 8'hC0, 8'hC0, 8'hC0, 8'hC0, "t1");
        drain();

        // 2: one load, committed at the first boundary
        do_reset("t2");
        push_rdy(2, 1'b1, "t2");
        push_rdy(3, 1'b0, "t2");
        push_rdy(19, 1'b0, "t2");
        push_rdy(20, 1'b1, "t2");
        push_frame(1'b0, 1, 8'hC0, 8'hC0, 8'hC0, 8'hC0, "t2f1");
        push_frame(1'b0, 2, 8'h99, 8'hB0, 8'hA4, 8'hF9, "t2f2");
        load(2, 16'h1234, 4'h0);
        drain();

        // 3: backpressure, second word held until the slot frees
        do_reset("t3");
        push_rdy(19, 1'b0, "t3");
        push_rdy(20, 1'b1, "t3");
        push_rdy(21, 1'b0, "t3");
        push_frame(1'b0, 2, 8'h88, 8'h88, 8'h88, 8'h88, "t3f2");
        push_frame(1'b0, 3, 8'h92, 8'h92, 8'h92, 8'h92, "t3f3");
        goto(2);
        load_valid = 1'b1;
        load_data  = 16'hAAAA;
        load_dp    = 4'h0;
        goto(3);
        load_data  = 16'h5555;
        goto(21);
        load_valid = 1'b0;
        drain();

        // 3b: load on the boundary cycle goes to pending, not straight to display
        do_reset("t3b");
        push_rdy(19, 1'b1, "t3b");
        push_rdy(20, 1'b0, "t3b");
        push_frame(1'b0, 2, 8'hC0, 8'hC0, 8'hC0, 8'hC0, "t3bf2");
        push_frame(1'b0, 3, 8'h99, 8'hB0, 8'hA4, 8'hF9, "t3bf3");
        load(19, 16'h1234, 4'h0);
        drain();

        // 4: leading-zero blanking vs. plain instance, dp kept on blanked digit
        do_reset("t4");
        push_frame(1'b1, 2, 8'h92, 8'h88, 8'hFF, 8'hFF, "t4lzf2");
        push_frame(1'b0, 2, 8'h92, 8'h88, 8'hC0, 8'hC0, "t4f2");
        push_frame(1'b1, 3, 8'hC0, 8'hFF, 8'hFF, 8'h7F, "t4lzf3");
        push_frame(1'b0, 3, 8'hC0, 8'hC0, 8'hC0, 8'h40, "t4f3");
        load(0, 16'h00A5, 4'h0);
        load(20, 16'h0000, 4'b1000);
        drain();

        // 5: decimal point on digit 2
        do_reset("t5");
        push_frame(1'b0, 2, 8'h80, 8'h80, 8'h00, 8'h80, "t5f2");
        load(0, 16'h8888, 4'b0100);
        drain();

        // 6: reset during digit 2 with pending full discards everything
        load(40, 16'h4321, 4'h0);
        goto(50);
        do_reset("t6");
        push_rdy(0, 1'b1, "t6");
        push_frame(1'b0, 1, 8'hC0, 8'hC0, 8'hC0, 8'hC0, "t6f1");
        push_frame(1'b0, 2, 8'hC0, 8'hC0, 8'hC0, 8'hC0, "t6f2");
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
